dma_sched: RTL

Descriptor-queue controller for the DMA engine. It sits between the CPU auxiliary data bus and the DMA configuration port. The CPU pushes up to DEPTH transfer descriptors into a FIFO. The scheduler then programs the DMA parameter registers one descriptor at a time, starts each transfer, and acknowledges the DMA interrupt when the transfer finishes. It raises a single CPU interrupt once the queue drains, so back-to-back transfers run without CPU involvement between them.

---
 rtl/dma_pkg.sv | 53 +++++
 rtl/dma_desc_fifo.sv | 73 +++++++
 rtl/dma_sched.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// Shared DMA definitions: parameter register offsets, scheduler FSM encoding
// and the 40-bit descriptor layout used by the descriptor queue.
package dma_pkg;

  localparam logic [2:0] REG_START = 3'd0;
  localparam logic [2:0] REG_SRCL  = 3'd1;
  localparam logic [2:0] REG_SRCH  = 3'd2;
  localparam logic [2:0] REG_DSTL  = 3'd3;
  localparam logic [2:0] REG_DSTH  = 3'd4;
  localparam logic [2:0] REG_N     = 3'd5;

  localparam logic [2:0] LOAD_LAST = 3'd5;
  localparam int         DESC_W    = 40;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_ACK  = 2'd3
  } state_e;

  typedef struct packed {
    logic [7:0] n;
    logic [7:0] dst_hi;
    logic [7:0] dst_lo;
    logic [7:0] src_hi;
    logic [7:0] src_lo;
  } desc_t;

  // START is written last so the DMA only kicks off once all parameters are in place.
  function automatic logic [2:0] load_reg(input logic [2:0] idx);
    case (idx)
      3'd0:    load_reg = REG_SRCL;
      3'd1:    load_reg = REG_SRCH;
      3'd2:    load_reg = REG_DSTL;
      3'd3:    load_reg = REG_DSTH;
      3'd4:    load_reg = REG_N;
      default: load_reg = REG_START;
    endcase
  endfunction

  function automatic logic [7:0] load_byte(input desc_t d, input logic [2:0] idx);
    case (idx)
      3'd0:    load_byte = d.src_lo;
      3'd1:    load_byte = d.src_hi;
      3'd2:    load_byte = d.dst_lo;
      3'd3:    load_byte = d.dst_hi;
      3'd4:    load_byte = d.n;
      default: load_byte = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/dma_desc_fifo.sv
// Synchronous descriptor FIFO. A flush can optionally keep the current head,
// which is the entry the scheduler is transferring.
module dma_desc_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 40
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic                       flush_keep_head_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok_s, pop_ok_s, keep_s, we_s;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == {CW{1'b0}});
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  always_comb begin
    pop_ok_s  = pop_i && !empty_o;
    // A pop frees the slot in the same edge, so a push into a full queue is accepted.
    push_ok_s = push_i && (!full_o || pop_ok_s);
    keep_s    = flush_keep_head_i && !empty_o;
    rptr_d    = rptr_q;
    wptr_d    = wptr_q;
    count_d   = count_q;
    we_s      = 1'b0;
    if (flush_i) begin
      rptr_d  = rptr_q + PW'(keep_s && pop_ok_s);
      wptr_d  = rptr_q + PW'(keep_s);
      count_d = CW'(keep_s && !pop_ok_s);
    end else begin
      rptr_d  = rptr_q + PW'(pop_ok_s);
      wptr_d  = wptr_q + PW'(push_ok_s);
      count_d = count_q + CW'(push_ok_s) - CW'(pop_ok_s);
      we_s    = push_ok_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q  <= {PW{1'b0}};
      wptr_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/dma_sched.sv
// Descriptor-queue scheduler: CPU register window, descriptor FIFO and the FSM
// that programs the DMA one descriptor at a time and raises irq when drained.
module dma_sched
  import dma_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] BASE     = 16'h0110,
  parameter logic [15:0] DMA_BASE = 16'h0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] auxdaddr,
  input  logic [7:0]  auxdin,
  input  logic        auxwe,
  output logic [7:0]  auxdout,
  output logic        auxdoutsel,
  input  logic        ack,
  output logic        irq,
  output logic        dmasel,
  output logic [15:0] dmaaddr,
  output logic [7:0]  dmadin,
  input  logic        dmairq,
  output logic        dmaack
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  desc_t         stage_q, stage_d;
  logic          ien_q, ien_d;
  logic          ovf_q, ovf_d;
  logic          irq_q, irq_d;

  logic [15:0]   off_s;
  logic          win_s, wr_s, ctrl_wr_s, push_s, flush_s, pop_s;
  logic          busy_s, more_s, irq_set_s;
  logic          full_s, empty_s;
  logic [CW-1:0] count_s;
  desc_t         head_s;
  logic [7:0]    status_s, rd_s;
  logic          unused_ctrl_bits_s;

  assign off_s      = auxdaddr - BASE;
  assign win_s      = (off_s < 16'd7);
  assign wr_s       = auxwe && win_s;
  assign ctrl_wr_s  = wr_s && (off_s == 16'd0);
  assign push_s     = ctrl_wr_s && auxdin[0];
  assign flush_s    = ctrl_wr_s && auxdin[1];
  assign pop_s      = (state_q == ST_ACK);
  assign busy_s     = (state_q != ST_IDLE);
  // A flush in ACK leaves nothing behind the popped head, so the queue ends there.
  assign more_s     = (count_s > CW'(1)) && !flush_s;
  assign unused_ctrl_bits_s = ^auxdin[6:3];

  dma_desc_fifo #(
    .DEPTH (DEPTH),
    .W     (DESC_W)
  ) u_fifo (
    .clk               (clk),
    .rst               (rst),
    .push_i            (push_s),
    .pop_i             (pop_s),
    .flush_i           (flush_s),
    .flush_keep_head_i (busy_s),
    .wdata_i           (stage_q),
    .rdata_o           (head_s),
    .full_o            (full_s),
    .empty_o           (empty_s),
    .count_o           (count_s)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    irq_set_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_s && !flush_s) begin
          state_d = ST_LOAD;
          idx_d   = 3'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (idx_q == LOAD_LAST) begin
          state_d = ST_WAIT;
          idx_d   = 3'd0;
        end else begin
          idx_d   = idx_q + 3'd1;
        end
      end
      ST_WAIT: begin
        if (dmairq) begin
          state_d = ST_ACK;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_ACK: begin
        if (more_s) begin
          state_d = ST_LOAD;
          idx_d   = 3'd0;
        end else begin
          state_d   = ST_IDLE;
          irq_set_s = ien_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 3'd0;
      end
    endcase
  end

  always_comb begin
    stage_d = stage_q;
    ien_d   = ien_q;
    ovf_d   = ovf_q;
    irq_d   = irq_q;
    if (wr_s) begin
      case (off_s[2:0])
        3'd0: begin
          ien_d = auxdin[7];
          if (auxdin[2]) begin
            ovf_d = 1'b0;
          end else begin
            ovf_d = ovf_q;
          end
        end
        3'd1:    stage_d.src_lo = auxdin;
        3'd2:    stage_d.src_hi = auxdin;
        3'd3:    stage_d.dst_lo = auxdin;
        3'd4:    stage_d.dst_hi = auxdin;
        3'd5:    stage_d.n      = auxdin;
        default: stage_d        = stage_q;
      endcase
    end else begin
      stage_d = stage_q;
    end
    if (push_s && !flush_s && full_s && !pop_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_d;
    end
    if (irq_set_s) begin
      irq_d = 1'b1;
    end else if (ack) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      stage_q <= '0;
      ien_q   <= 1'b0;
      ovf_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      ien_q   <= ien_d;
      ovf_q   <= ovf_d;
      irq_q   <= irq_d;
    end
  end

  assign status_s = {busy_s, full_s, empty_s, ovf_q, ien_q, 3'(count_s)};

  always_comb begin
    rd_s = 8'h00;
    case (off_s[2:0])
      3'd0:    rd_s = {ien_q, 7'b0000000};
      3'd1:    rd_s = stage_q.src_lo;
      3'd2:    rd_s = stage_q.src_hi;
      3'd3:    rd_s = stage_q.dst_lo;
      3'd4:    rd_s = stage_q.dst_hi;
      3'd5:    rd_s = stage_q.n;
      3'd6:    rd_s = status_s;
      default: rd_s = 8'h00;
    endcase
  end

  assign auxdoutsel = win_s;
  assign auxdout    = win_s ? rd_s : 8'h00;
  assign irq        = irq_q;
  assign dmasel     = busy_s;
  assign dmaack     = (state_q == ST_ACK);
  assign dmaaddr    = (state_q == ST_LOAD) ? (DMA_BASE + {13'd0, load_reg(idx_q)}) : 16'h0000;
  assign dmadin     = (state_q == ST_LOAD) ? load_byte(head_s, idx_q) : 8'h00;

endmodule
